vga_line_render: RTL and testbench

// 800x600@72Hz VGA core: display timing, Bresenham line rasteriser and WIDTHxHEIGHT framebuffer.

---
 rtl/vga_line_render_pkg.sv | 32 +++
 rtl/vga_line_render_line_rasteriser.sv | 133 +++++++++++++
 rtl/vga_line_render.sv | 219 +++++++++++++++++++++
 tb/tb_vga_line_render.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_line_render_pkg.sv
// Shared definitions for the vga_line_render slice.
// Contents:
//   - 800x600@72Hz display timing constants, including the 1040/666 totals
//   - rasteriser state enum
//   - fb_index(): linear framebuffer address from an (x,y) pair
package vga_line_render_pkg;

  localparam int VGA_H_RES   = 800;
  localparam int VGA_H_FP    = 56;
  localparam int VGA_H_SP    = 120;
  localparam int VGA_H_BP    = 64;
  localparam int VGA_H_TOTAL = VGA_H_RES + VGA_H_FP + VGA_H_SP + VGA_H_BP;

  localparam int VGA_V_RES   = 600;
  localparam int VGA_V_FP    = 37;
  localparam int VGA_V_SP    = 6;
  localparam int VGA_V_BP    = 23;
  localparam int VGA_V_TOTAL = VGA_V_RES + VGA_V_FP + VGA_V_SP + VGA_V_BP;

  typedef enum logic [1:0] {
    RAST_IDLE,
    RAST_INIT,
    RAST_DRAW,
    RAST_DONE
  } rast_state_t;

  // Row-major framebuffer addressing.
  function automatic int fb_index(input int x, input int y, input int width);
    return y * width + x;
  endfunction

endpackage

// File: rtl/vga_line_render_line_rasteriser.sv
// Bresenham line rasteriser FSM (IDLE -> INIT -> DRAW -> DONE -> IDLE).
// Ports:
//   clk_pix, rst        pixel clock, synchronous active-low reset
//   i_start             line request, only honoured in IDLE
//   i_step              advance enable; while low the current pixel is held
//   i_x0/i_y0/i_x1/i_y1 endpoints, i_color line colour
//   o_x/o_y/o_color     current pixel and its colour, valid while o_drawing
//   o_drawing           current pixel valid
//   o_done              one-cycle pulse after the last pixel
module vga_line_render_line_rasteriser
  import vga_line_render_pkg::*;
#(
  parameter int XY_BITW = 11,
  parameter int COLORW  = 3
) (
  input  logic               clk_pix,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_step,
  input  logic [XY_BITW-1:0] i_x0,
  input  logic [XY_BITW-1:0] i_y0,
  input  logic [XY_BITW-1:0] i_x1,
  input  logic [XY_BITW-1:0] i_y1,
  input  logic [COLORW-1:0]  i_color,
  output logic [XY_BITW-1:0] o_x,
  output logic [XY_BITW-1:0] o_y,
  output logic [COLORW-1:0]  o_color,
  output logic               o_drawing,
  output logic               o_done
);

  // Two extra bits: one for sign, one so dx+dy never overflows.
  localparam int EW = XY_BITW + 2;

  rast_state_t          r_state;
  logic [XY_BITW-1:0]   r_x;
  logic [XY_BITW-1:0]   r_y;
  logic [XY_BITW-1:0]   r_xEnd;
  logic [XY_BITW-1:0]   r_yEnd;
  logic [COLORW-1:0]    r_color;
  logic signed [EW-1:0] r_dx;
  logic signed [EW-1:0] r_dy;
  logic signed [EW-1:0] r_err;
  logic                 r_xNeg;
  logic                 r_yNeg;
  logic                 r_drawing;
  logic                 r_done;

  logic signed [EW-1:0] w_diffX;
  logic signed [EW-1:0] w_diffY;
  logic signed [EW-1:0] w_absX;
  logic signed [EW-1:0] w_absY;
  logic signed [EW:0]   w_e2;
  logic signed [EW:0]   w_dxExt;
  logic signed [EW:0]   w_dyExt;
  logic                 w_stepX;
  logic                 w_stepY;
  logic                 w_atEnd;

  // Deltas are taken from the latched start point in r_x/r_y while in INIT.
  // e2 gets one extra bit so doubling err cannot wrap.
  always_comb begin
    w_diffX = $signed({2'b00, r_xEnd}) - $signed({2'b00, r_x});
    w_diffY = $signed({2'b00, r_yEnd}) - $signed({2'b00, r_y});
    w_absX  = w_diffX[EW-1] ? -w_diffX : w_diffX;
    w_absY  = w_diffY[EW-1] ? -w_diffY : w_diffY;
    w_e2    = {r_err, 1'b0};
    w_dxExt = {r_dx[EW-1], r_dx};
    w_dyExt = {r_dy[EW-1], r_dy};
    w_stepX = (w_e2 >= w_dyExt);
    w_stepY = (w_e2 <= w_dxExt);
    w_atEnd = (r_x == r_xEnd) && (r_y == r_yEnd);
  end

  // Endpoints are captured on the accepted start so the source may change
  // them immediately. Both error updates use the pre-step err value.
  always_ff @(posedge clk_pix) begin
    if (!rst) begin
      r_state   <= RAST_IDLE;
      r_drawing <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RAST_IDLE: begin
          if (i_start) begin
            r_x     <= i_x0;
            r_y     <= i_y0;
            r_xEnd  <= i_x1;
            r_yEnd  <= i_y1;
            r_color <= i_color;
            r_state <= RAST_INIT;
          end
        end
        RAST_INIT: begin
          r_dx      <= w_absX;
          r_dy      <= -w_absY;
          r_err     <= w_absX - w_absY;
          r_xNeg    <= w_diffX[EW-1];
          r_yNeg    <= w_diffY[EW-1];
          r_drawing <= 1'b1;
          r_state   <= RAST_DRAW;
        end
        RAST_DRAW: begin
          if (i_step) begin
            if (w_atEnd) begin
              r_drawing <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= RAST_DONE;
            end else begin
              r_err <= r_err + (w_stepX ? r_dy : '0) + (w_stepY ? r_dx : '0);
              if (w_stepX) r_x <= r_xNeg ? r_x - 1'b1 : r_x + 1'b1;
              if (w_stepY) r_y <= r_yNeg ? r_y - 1'b1 : r_y + 1'b1;
            end
          end
        end
        RAST_DONE: begin
          r_state <= RAST_IDLE;
        end
        default: begin
          r_state <= RAST_IDLE;
        end
      endcase
    end
  end

  assign o_x       = r_x;
  assign o_y       = r_y;
  assign o_color   = r_color;
  assign o_drawing = r_drawing;
  assign o_done    = r_done;

endmodule

// File: rtl/vga_line_render.sv
// 800x600@72Hz VGA core with a Bresenham line rasteriser writing into a
// WIDTHxHEIGHT framebuffer that is scanned out at (POSX,POSY).
// Ports:
//   clk_pix, rst             pixel clock, synchronous active-low reset
//   i_start, i_draw_oe       line request pulse, rasteriser step enable
//   i_x0/i_y0/i_x1/i_y1      line endpoints in framebuffer coordinates
//   i_color                  line colour
//   o_drawing, o_done        pixel valid, one-cycle completion pulse
//   o_sx, o_sy, o_de, o_frame scan position, active video, frame tick
//   o_hsync, o_vsync         syncs, delayed one cycle to line up with rgb
//   o_vga_r/g/b              1-bit colour pins
// Optional build macro VGA_LINE_RENDER_CLEAR_EN adds i_clear (pulse) and
// o_clear_busy: the framebuffer is swept to zero, one address per cycle, and
// line starts are ignored while the sweep runs. Without it the framebuffer
// holds its power-up (all zero) contents until lines are drawn.
module vga_line_render
  import vga_line_render_pkg::*;
#(
  parameter int XY_BITW = 11,
  parameter int H_RES   = VGA_H_RES,
  parameter int H_FP    = VGA_H_FP,
  parameter int H_SP    = VGA_H_SP,
  parameter int H_BP    = VGA_H_BP,
  parameter bit H_POL   = 1'b1,
  parameter int V_RES   = VGA_V_RES,
  parameter int V_FP    = VGA_V_FP,
  parameter int V_SP    = VGA_V_SP,
  parameter int V_BP    = VGA_V_BP,
  parameter bit V_POL   = 1'b1,
  parameter int WIDTH   = 32,
  parameter int HEIGHT  = 32,
  parameter int COLORW  = 3,
  parameter int POSX    = 200,
  parameter int POSY    = 200
) (
  input  logic               clk_pix,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_draw_oe,
  input  logic [XY_BITW-1:0] i_x0,
  input  logic [XY_BITW-1:0] i_y0,
  input  logic [XY_BITW-1:0] i_x1,
  input  logic [XY_BITW-1:0] i_y1,
  input  logic [COLORW-1:0]  i_color,
`ifdef VGA_LINE_RENDER_CLEAR_EN
  input  logic               i_clear,
  output logic               o_clear_busy,
`endif
  output logic               o_drawing,
  output logic               o_done,
  output logic [XY_BITW-1:0] o_sx,
  output logic [XY_BITW-1:0] o_sy,
  output logic               o_de,
  output logic               o_frame,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_vga_r,
  output logic               o_vga_g,
  output logic               o_vga_b
);

  localparam int H_TOTAL  = H_RES + H_FP + H_SP + H_BP;
  localparam int V_TOTAL  = V_RES + V_FP + V_SP + V_BP;
  localparam int FB_DEPTH = WIDTH * HEIGHT;
  localparam int AW       = $clog2(FB_DEPTH);

  localparam logic [XY_BITW-1:0] L_H_LAST   = XY_BITW'(H_TOTAL - 1);
  localparam logic [XY_BITW-1:0] L_V_LAST   = XY_BITW'(V_TOTAL - 1);
  localparam logic [XY_BITW-1:0] L_H_RES    = XY_BITW'(H_RES);
  localparam logic [XY_BITW-1:0] L_V_RES    = XY_BITW'(V_RES);
  localparam logic [XY_BITW-1:0] L_HS_START = XY_BITW'(H_RES + H_FP);
  localparam logic [XY_BITW-1:0] L_HS_END   = XY_BITW'(H_RES + H_FP + H_SP);
  localparam logic [XY_BITW-1:0] L_VS_START = XY_BITW'(V_RES + V_FP);
  localparam logic [XY_BITW-1:0] L_VS_END   = XY_BITW'(V_RES + V_FP + V_SP);
  localparam logic [XY_BITW-1:0] L_WIN_X0   = XY_BITW'(POSX);
  localparam logic [XY_BITW-1:0] L_WIN_X1   = XY_BITW'(POSX + WIDTH);
  localparam logic [XY_BITW-1:0] L_WIN_Y0   = XY_BITW'(POSY);
  localparam logic [XY_BITW-1:0] L_WIN_Y1   = XY_BITW'(POSY + HEIGHT);
  localparam logic [XY_BITW-1:0] L_WIDTH    = XY_BITW'(WIDTH);
  localparam logic [XY_BITW-1:0] L_HEIGHT   = XY_BITW'(HEIGHT);

  logic [XY_BITW-1:0] r_sx;
  logic [XY_BITW-1:0] r_sy;
  logic               r_de;
  logic               r_frame;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_hit;
  logic [COLORW-1:0]  r_rdData;
  logic [COLORW-1:0]  r_fb [FB_DEPTH];

  logic [XY_BITW-1:0] w_sxNext;
  logic [XY_BITW-1:0] w_syNext;
  logic               w_hit;
  logic [AW-1:0]      w_rdAddr;
  logic               w_start;
  logic [XY_BITW-1:0] w_rastX;
  logic [XY_BITW-1:0] w_rastY;
  logic [COLORW-1:0]  w_rastColor;
  logic               w_rastWe;
  logic [AW-1:0]      w_rastAddr;
  logic               w_we;
  logic [AW-1:0]      w_wrAddr;
  logic [COLORW-1:0]  w_wrData;

  // Scan counters: sx wraps at the end of the line and carries into sy.
  always_comb begin
    w_sxNext = r_sx + 1'b1;
    w_syNext = r_sy;
    if (r_sx == L_H_LAST) begin
      w_sxNext = '0;
      w_syNext = (r_sy == L_V_LAST) ? '0 : r_sy + 1'b1;
    end
  end

  // de/frame are computed from the next position so they stay aligned with
  // sx/sy, and read 0 while reset is held. Syncs are decoded from the current
  // position, which delays them one cycle to match the RAM read latency.
  always_ff @(posedge clk_pix) begin
    if (!rst) begin
      r_sx    <= '0;
      r_sy    <= '0;
      r_de    <= 1'b0;
      r_frame <= 1'b0;
      r_hsync <= ~H_POL;
      r_vsync <= ~V_POL;
      r_hit   <= 1'b0;
    end else begin
      r_sx    <= w_sxNext;
      r_sy    <= w_syNext;
      r_de    <= (w_sxNext < L_H_RES) && (w_syNext < L_V_RES);
      r_frame <= (w_sxNext == '0) && (w_syNext == L_V_RES);
      r_hsync <= ((r_sx >= L_HS_START) && (r_sx < L_HS_END)) ? H_POL : ~H_POL;
      r_vsync <= ((r_sy >= L_VS_START) && (r_sy < L_VS_END)) ? V_POL : ~V_POL;
      r_hit   <= w_hit;
    end
  end

  assign w_hit = r_de && (r_sx >= L_WIN_X0) && (r_sx < L_WIN_X1)
                      && (r_sy >= L_WIN_Y0) && (r_sy < L_WIN_Y1);
  assign w_rdAddr = AW'(fb_index(int'(r_sx - L_WIN_X0), int'(r_sy - L_WIN_Y0), WIDTH));

  vga_line_render_line_rasteriser #(
    .XY_BITW (XY_BITW),
    .COLORW  (COLORW)
  ) u_line_rasteriser (
    .clk_pix   (clk_pix),
    .rst       (rst),
    .i_start   (w_start),
    .i_step    (i_draw_oe),
    .i_x0      (i_x0),
    .i_y0      (i_y0),
    .i_x1      (i_x1),
    .i_y1      (i_y1),
    .i_color   (i_color),
    .o_x       (w_rastX),
    .o_y       (w_rastY),
    .o_color   (w_rastColor),
    .o_drawing (o_drawing),
    .o_done    (o_done)
  );

  // Pixels off the framebuffer are dropped rather than wrapped into the
  // next row by the linear address.
  assign w_rastWe   = o_drawing && i_draw_oe && (w_rastX < L_WIDTH) && (w_rastY < L_HEIGHT);
  assign w_rastAddr = AW'(fb_index(int'(w_rastX), int'(w_rastY), WIDTH));

`ifdef VGA_LINE_RENDER_CLEAR_EN
  logic          r_clrBusy;
  logic [AW-1:0] r_clrAddr;

  // Clear sweep owns the write port while busy; a rasteriser write landing
  // during the sweep is lost, which is harmless since the buffer is being wiped.
  always_ff @(posedge clk_pix) begin
    if (!rst) begin
      r_clrBusy <= 1'b0;
      r_clrAddr <= '0;
    end else if (r_clrBusy) begin
      r_clrAddr <= r_clrAddr + 1'b1;
      if (r_clrAddr == AW'(FB_DEPTH - 1)) r_clrBusy <= 1'b0;
    end else if (i_clear) begin
      r_clrBusy <= 1'b1;
      r_clrAddr <= '0;
    end
  end

  assign w_start      = i_start && !r_clrBusy;
  assign w_we         = r_clrBusy || w_rastWe;
  assign w_wrAddr     = r_clrBusy ? r_clrAddr : w_rastAddr;
  assign w_wrData     = r_clrBusy ? '0 : w_rastColor;
  assign o_clear_busy = r_clrBusy;
`else
  assign w_start  = i_start;
  assign w_we     = w_rastWe;
  assign w_wrAddr = w_rastAddr;
  assign w_wrData = w_rastColor;
`endif

  // Simple dual-port RAM: separate write and read processes, so a read of
  // the address being written returns the old contents.
  always_ff @(posedge clk_pix) begin
    if (w_we) r_fb[w_wrAddr] <= w_wrData;
  end

  always_ff @(posedge clk_pix) begin
    r_rdData <= r_fb[w_rdAddr];
  end

  assign o_sx    = r_sx;
  assign o_sy    = r_sy;
  assign o_de    = r_de;
  assign o_frame = r_frame;
  assign o_hsync = r_hsync;
  assign o_vsync = r_vsync;
  assign o_vga_r = r_hit & r_rdData[2];
  assign o_vga_g = r_hit & r_rdData[1];
  assign o_vga_b = r_hit & r_rdData[0];

endmodule

// File: tb/tb_vga_line_render.sv
// Directed testbench for vga_line_render. The window is moved to POSY=4 so
// scan-out of the framebuffer is reachable within a few thousand cycles;
// horizontal timing and POSX keep their defaults.
module tb_vga_line_render;

  localparam int XY_BITW = 11;
  localparam int COLORW  = 3;
  localparam int POSY_TB = 4;

  logic               clk_pix = 1'b0;
  logic               rst = 1'b0;
  logic               i_start = 1'b0;
  logic               i_draw_oe = 1'b1;
  logic [XY_BITW-1:0] i_x0 = '0;
  logic [XY_BITW-1:0] i_y0 = '0;
  logic [XY_BITW-1:0] i_x1 = '0;
  logic [XY_BITW-1:0] i_y1 = '0;
  logic [COLORW-1:0]  i_color = '0;
`ifdef VGA_LINE_RENDER_CLEAR_EN
  logic               i_clear = 1'b0;
  logic               o_clear_busy;
`endif
  logic               o_drawing;
  logic               o_done;
  logic [XY_BITW-1:0] o_sx;
  logic [XY_BITW-1:0] o_sy;
  logic               o_de;
  logic               o_frame;
  logic               o_hsync;
  logic               o_vsync;
  logic               o_vga_r;
  logic               o_vga_g;
  logic               o_vga_b;
  logic [2:0]         rgb;

  int nCompared = 0;
  int nMismatched = 0;

  int capX [64];
  int capY [64];
  int capN;
  int capFirst;
  int capLast;
  int capDone;
  int capDoneCnt;
  int capStallDraw;

  always #10 clk_pix = ~clk_pix;

  assign rgb = {o_vga_r, o_vga_g, o_vga_b};

  vga_line_render #(
    .POSY (POSY_TB)
  ) dut (
    .clk_pix      (clk_pix),
    .rst          (rst),
    .i_start      (i_start),
    .i_draw_oe    (i_draw_oe),
    .i_x0         (i_x0),
    .i_y0         (i_y0),
    .i_x1         (i_x1),
    .i_y1         (i_y1),
    .i_color      (i_color),
`ifdef VGA_LINE_RENDER_CLEAR_EN
    .i_clear      (i_clear),
    .o_clear_busy (o_clear_busy),
`endif
    .o_drawing    (o_drawing),
    .o_done       (o_done),
    .o_sx         (o_sx),
    .o_sy         (o_sy),
    .o_de         (o_de),
    .o_frame      (o_frame),
    .o_hsync      (o_hsync),
    .o_vsync      (o_vsync),
    .o_vga_r      (o_vga_r),
    .o_vga_g      (o_vga_g),
    .o_vga_b      (o_vga_b)
  );

  // Bounded wait for a scan position, sampled on falling edges.
  task automatic wait_scan(input int x, input int y, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_pix);
      if (int'(o_sx) == x && int'(o_sy) == y) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Pulses start and records every written pixel for 40 cycles. Cycle c=1 is
  // the first falling edge after the start edge. stallFrom>0 drops draw_oe
  // for three cycles beginning at that cycle.
  task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                          input logic [2:0] col, input int stallFrom);
    for (int i = 0; i < 64; i++) begin
      capX[i] = -1;
      capY[i] = -1;
    end
    capN = 0; capFirst = -1; capLast = -1; capDone = -1; capDoneCnt = 0; capStallDraw = 0;
    i_x0 = XY_BITW'(x0); i_y0 = XY_BITW'(y0); i_x1 = XY_BITW'(x1); i_y1 = XY_BITW'(y1);
    i_color = col; i_draw_oe = 1'b1; i_start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_pix);
      i_start = 1'b0;
      i_draw_oe = !(stallFrom > 0 && c >= stallFrom && c < stallFrom + 3);
      if (o_drawing && i_draw_oe && capN < 64) begin
        capX[capN] = int'(dut.u_line_rasteriser.o_x);
        capY[capN] = int'(dut.u_line_rasteriser.o_y);
        if (capFirst < 0) capFirst = c;
        capLast = c;
        capN++;
      end
      if (o_drawing && !i_draw_oe) capStallDraw++;
      if (o_done) begin
        capDoneCnt++;
        if (capDone < 0) capDone = c;
      end
    end
    i_draw_oe = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk_pix);
    nCompared++; if (o_sx !== '0) begin nMismatched++; $display("[TB] FAIL reset_sx: got %0d expected 0", o_sx); end
    nCompared++; if (o_sy !== '0) begin nMismatched++; $display("[TB] FAIL reset_sy: got %0d expected 0", o_sy); end
    nCompared++; if ({o_de, o_frame} !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_de_frame: got %b expected 00", {o_de, o_frame}); end
    nCompared++; if ({o_hsync, o_vsync} !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_syncs: got %b expected 00", {o_hsync, o_vsync}); end
    nCompared++; if (rgb !== 3'b000) begin nMismatched++; $display("[TB] FAIL reset_rgb: got %b expected 000", rgb); end
    nCompared++; if ({o_drawing, o_done} !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_draw_done: got %b expected 00", {o_drawing, o_done}); end
    rst = 1'b1;
  endtask

  task automatic test_timing();
    bit ok;
    int hsCount;
    int firstHs;
    int n;
    wait_scan(799, 0, 2000, ok);
    nCompared++; if (!ok || o_de !== 1'b1) begin nMismatched++; $display("[TB] FAIL de_sx799: got %b (found %0d) expected 1", o_de, ok); end
    @(negedge clk_pix);
    nCompared++; if (o_sx !== 11'd800 || o_de !== 1'b0) begin nMismatched++; $display("[TB] FAIL de_sx800: got sx=%0d de=%b expected sx=800 de=0", o_sx, o_de); end
    wait_scan(856, 0, 200, ok);
    nCompared++; if (!ok || o_hsync !== 1'b0) begin nMismatched++; $display("[TB] FAIL hsync_at856: got %b (found %0d) expected 0", o_hsync, ok); end
    hsCount = 0;
    firstHs = -1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_pix);
      if (o_hsync) begin
        hsCount++;
        if (firstHs < 0) firstHs = int'(o_sx);
      end
    end
    nCompared++; if (hsCount != 120) begin nMismatched++; $display("[TB] FAIL hsync_width: got %0d expected 120", hsCount); end
    nCompared++; if (firstHs != 857) begin nMismatched++; $display("[TB] FAIL hsync_first_sx: got %0d expected 857", firstHs); end
    wait_scan(1039, 0, 200, ok);
    nCompared++; if (!ok) begin nMismatched++; $display("[TB] FAIL line_end_reach: got 0 expected 1"); end
    @(negedge clk_pix);
    nCompared++; if (o_sx !== '0 || o_sy !== 11'd1) begin nMismatched++; $display("[TB] FAIL line_wrap: got sx=%0d sy=%0d expected sx=0 sy=1", o_sx, o_sy); end
    n = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk_pix);
      if (o_sx == '0) begin
        n = i;
        break;
      end
    end
    nCompared++; if (n != 1040 || o_sy !== 11'd2) begin nMismatched++; $display("[TB] FAIL line_length: got %0d cycles sy=%0d expected 1040 sy=2", n, o_sy); end
  endtask

  task automatic test_horizontal();
    run_line(0, 0, 5, 0, 3'b001, 0);
    nCompared++; if (capN != 6) begin nMismatched++; $display("[TB] FAIL horiz_count: got %0d expected 6", capN); end
    nCompared++; if (capFirst != 2) begin nMismatched++; $display("[TB] FAIL horiz_latency: got %0d expected 2", capFirst); end
    nCompared++; if (capDone != 8 || capDoneCnt != 1) begin nMismatched++; $display("[TB] FAIL horiz_done: got cycle %0d count %0d expected cycle 8 count 1", capDone, capDoneCnt); end
    for (int i = 0; i < 6; i++) begin
      nCompared++; if (capX[i] != i || capY[i] != 0) begin nMismatched++; $display("[TB] FAIL horiz_px%0d: got (%0d,%0d) expected (%0d,0)", i, capX[i], capY[i], i); end
    end
  endtask

  task automatic test_diagonal();
    run_line(0, 0, 3, 3, 3'b010, 0);
    nCompared++; if (capN != 4) begin nMismatched++; $display("[TB] FAIL diag_count: got %0d expected 4", capN); end
    for (int i = 0; i < 4; i++) begin
      nCompared++; if (capX[i] != i || capY[i] != i) begin nMismatched++; $display("[TB] FAIL diag_px%0d: got (%0d,%0d) expected (%0d,%0d)", i, capX[i], capY[i], i, i); end
    end
    nCompared++; if (capDone != capLast + 1) begin nMismatched++; $display("[TB] FAIL diag_done: got cycle %0d expected %0d", capDone, capLast + 1); end
  endtask

  task automatic test_reverse();
    int ex [6] = '{2, 2, 2, 1, 1, 1};
    int ey [6] = '{5, 4, 3, 2, 1, 0};
    run_line(2, 5, 1, 0, 3'b110, 0);
    nCompared++; if (capN != 6) begin nMismatched++; $display("[TB] FAIL rev_count: got %0d expected 6", capN); end
    for (int i = 0; i < 6; i++) begin
      nCompared++; if (capX[i] != ex[i] || capY[i] != ey[i]) begin nMismatched++; $display("[TB] FAIL rev_px%0d: got (%0d,%0d) expected (%0d,%0d)", i, capX[i], capY[i], ex[i], ey[i]); end
    end
  endtask

  task automatic test_stall();
    run_line(0, 0, 5, 0, 3'b001, 4);
    nCompared++; if (capN != 6) begin nMismatched++; $display("[TB] FAIL stall_count: got %0d expected 6", capN); end
    nCompared++; if (capStallDraw != 3) begin nMismatched++; $display("[TB] FAIL stall_drawing_held: got %0d expected 3", capStallDraw); end
    for (int i = 0; i < 6; i++) begin
      nCompared++; if (capX[i] != i || capY[i] != 0) begin nMismatched++; $display("[TB] FAIL stall_px%0d: got (%0d,%0d) expected (%0d,0)", i, capX[i], capY[i], i); end
    end
    nCompared++; if (capDone != 11) begin nMismatched++; $display("[TB] FAIL stall_done: got %0d expected 11", capDone); end
  endtask

  // Runs past the right edge; x=32..34 must be dropped, not wrapped into row 2.
  task automatic test_overflow_line();
    run_line(30, 1, 34, 1, 3'b011, 0);
    nCompared++; if (capN != 5 || capX[4] != 34) begin nMismatched++; $display("[TB] FAIL ovf_count: got %0d last x %0d expected 5 last x 34", capN, capX[4]); end
  endtask

  task automatic test_abort();
    int doneSeen;
    i_x0 = '0; i_y0 = '0; i_x1 = 11'd10; i_y1 = '0; i_color = 3'b111; i_draw_oe = 1'b1;
    i_start = 1'b1;
    @(negedge clk_pix);
    i_start = 1'b0;
    repeat (3) @(negedge clk_pix);
    nCompared++; if (o_drawing !== 1'b1) begin nMismatched++; $display("[TB] FAIL abort_was_drawing: got %b expected 1", o_drawing); end
    rst = 1'b0;
    @(negedge clk_pix);
    nCompared++; if ({o_drawing, o_done} !== 2'b00) begin nMismatched++; $display("[TB] FAIL abort_cleared: got %b expected 00", {o_drawing, o_done}); end
    @(negedge clk_pix);
    rst = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_pix);
      if (o_done || o_drawing) doneSeen++;
    end
    nCompared++; if (doneSeen != 0) begin nMismatched++; $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", doneSeen); end
    run_line(0, 0, 0, 0, 3'b101, 0);
    nCompared++; if (capN != 1 || capX[0] != 0 || capY[0] != 0) begin nMismatched++; $display("[TB] FAIL point_px: got n=%0d (%0d,%0d) expected n=1 (0,0)", capN, capX[0], capY[0]); end
    nCompared++; if (capDone != 3 || capDoneCnt != 1) begin nMismatched++; $display("[TB] FAIL point_done: got cycle %0d count %0d expected cycle 3 count 1", capDone, capDoneCnt); end
  endtask

  // rgb sampled at sx shows the pixel fetched at sx-1.
  task automatic test_window();
    bit ok;
    wait_scan(201, POSY_TB - 1, 10000, ok);
    nCompared++; if (!ok || rgb !== 3'b000) begin nMismatched++; $display("[TB] FAIL win_above: got %b (found %0d) expected 000", rgb, ok); end
    wait_scan(200, POSY_TB, 2000, ok);
    nCompared++; if (!ok || rgb !== 3'b000) begin nMismatched++; $display("[TB] FAIL win_left_edge: got %b (found %0d) expected 000", rgb, ok); end
    @(negedge clk_pix);
    nCompared++; if (rgb !== 3'b101) begin nMismatched++; $display("[TB] FAIL win_px_0_0: got %b expected 101", rgb); end
    wait_scan(231, POSY_TB + 1, 2000, ok);
    nCompared++; if (!ok || rgb !== 3'b011) begin nMismatched++; $display("[TB] FAIL win_px_30_1: got %b (found %0d) expected 011", rgb, ok); end
    @(negedge clk_pix);
    nCompared++; if (rgb !== 3'b011) begin nMismatched++; $display("[TB] FAIL win_px_31_1: got %b expected 011", rgb); end
    @(negedge clk_pix);
    nCompared++; if (rgb !== 3'b000) begin nMismatched++; $display("[TB] FAIL win_right_edge: got %b expected 000", rgb); end
    wait_scan(201, POSY_TB + 2, 2000, ok);
    nCompared++; if (!ok || rgb !== 3'b000) begin nMismatched++; $display("[TB] FAIL win_drop_0_2: got %b (found %0d) expected 000", rgb, ok); end
    @(negedge clk_pix);
    nCompared++; if (rgb !== 3'b110) begin nMismatched++; $display("[TB] FAIL win_px_1_2: got %b expected 110", rgb); end
  endtask

  initial begin
    $display("[TB] starting vga_line_render bench");
    test_reset();
    test_timing();
    test_horizontal();
    test_diagonal();
    test_reverse();
    test_stall();
    test_overflow_line();
    test_abort();
    test_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #10ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
